// File: rtl/dynimage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dynimage_pkg
// Purpose  : Shared types and constants for the scrolling-image display
//            controller: FSM encoding, hex->7-segment table, blank codes.
// Revision : 1.0 - initial release
// ============================================================================
package dynimage_pkg;

  // Controller operating states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Blank codes (both outputs are active-low)
  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment patterns, bit order gfedcba, indexed by nibble value
  localparam logic [15:0][6:0] SEG_CODE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage : dynimage_pkg
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Purpose  : Combinational hex nibble to active-low 7-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg
  import dynimage_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_CODE[i_hex];

endmodule : hex7seg
`default_nettype wire

// File: rtl/dynimage_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dynimage_scan_ctrl
// Purpose  : 4-digit 7-segment scan/scroll controller with a nibble frame
//            buffer, run/pause/idle control and a host write port.
// Revision : 1.0 - initial release
// ============================================================================
module dynimage_scan_ctrl
  import dynimage_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int STEP_DIV = 25,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [3:0]    i_wr_data,
  output logic          o_wr_ack,
  output logic          o_running,
  output logic          o_step_pulse,
  output logic [3:0]    o_an,
  output logic [6:0]    o_seg
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  state_t              r_state;
  logic [AW-1:0]       r_base;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [1:0]          r_digit;
  logic [STEP_W-1:0]   r_round_cnt;
  logic [3:0]          r_mem [DEPTH];
  logic [3:0]          r_an;
  logic [6:0]          r_seg;
  logic                r_wr_ack;
  logic                r_step_pulse;

  logic                w_scan_tc;
  logic                w_round_tc;
  logic [SCAN_W-1:0]   w_scan_nxt;
  logic [1:0]          w_digit_nxt;
  logic [STEP_W-1:0]   w_round_nxt;
  logic [AW-1:0]       w_base_nxt;
  logic                w_step;
  logic [AW-1:0]       w_rd_addr;
  logic [3:0]          w_rd_nibble;
  logic [6:0]          w_seg_dec;
  logic [3:0]          w_an_nxt;
  logic                w_wr_ok;

  assign w_scan_tc  = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign w_round_tc = (r_round_cnt == STEP_W'(STEP_DIV - 1));
  assign w_wr_ok    = i_wr_en && (r_state != S_RUN);

  // Next scan position and scroll base; the scroll only moves in RUN at the end of digit 3
  always_comb begin
    w_scan_nxt  = w_scan_tc ? '0 : r_scan_cnt + 1'b1;
    w_digit_nxt = w_scan_tc ? r_digit + 1'b1 : r_digit;
    w_round_nxt = r_round_cnt;
    w_base_nxt  = r_base;
    w_step      = 1'b0;
    if (r_state == S_RUN && w_scan_tc && r_digit == 2'd3) begin
      if (w_round_tc) begin
        w_round_nxt = '0;
        w_base_nxt  = r_base + 1'b1;
        w_step      = 1'b1;
      end else begin
        w_round_nxt = r_round_cnt + 1'b1;
      end
    end
    // Leaving IDLE always restarts from digit 0 of a cleared base
    w_rd_addr = (r_state == S_IDLE) ? '0 : w_base_nxt + AW'(w_digit_nxt);
    w_an_nxt  = ~(4'b1000 >> w_digit_nxt);
  end

  assign w_rd_nibble = r_mem[w_rd_addr];

  hex7seg u_hex7seg (
    .i_hex (w_rd_nibble),
    .o_seg (w_seg_dec)
  );

  // Control FSM, frame buffer and registered display outputs; an/seg load together at slot start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_scan_cnt   <= '0;
      r_digit      <= '0;
      r_round_cnt  <= '0;
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_wr_ack     <= 1'b0;
      r_step_pulse <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_wr_ack     <= w_wr_ok;
      r_step_pulse <= 1'b0;
      if (w_wr_ok) begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            r_state     <= S_RUN;
            r_base      <= '0;
            r_scan_cnt  <= '0;
            r_digit     <= '0;
            r_round_cnt <= '0;
            r_an        <= 4'b0111;
            r_seg       <= w_seg_dec;
          end
        end
        S_RUN, S_PAUSE: begin
          if (r_state == S_PAUSE && i_stop) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_scan_cnt  <= '0;
            r_digit     <= '0;
            r_round_cnt <= '0;
            r_an        <= AN_OFF;
            r_seg       <= SEG_OFF;
          end else begin
            r_scan_cnt   <= w_scan_nxt;
            r_digit      <= w_digit_nxt;
            r_round_cnt  <= w_round_nxt;
            r_base       <= w_base_nxt;
            r_step_pulse <= w_step;
            if (w_scan_tc) begin
              r_an  <= w_an_nxt;
              r_seg <= w_seg_dec;
            end
            // stop has priority over start
            if (i_stop) begin
              r_state <= S_PAUSE;
            end else if (i_start) begin
              r_state <= S_RUN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wr_ack     = r_wr_ack;
  assign o_running    = (r_state == S_RUN);
  assign o_step_pulse = r_step_pulse;
  assign o_an         = r_an;
  assign o_seg        = r_seg;

endmodule : dynimage_scan_ctrl
`default_nettype wire

// File: tb/tb_dynimage_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dynimage_scan_ctrl
// Purpose  : Self-checking bench for dynimage_scan_ctrl: directed scenario
//            followed by random control/write traffic, compared each cycle
//            against a phase-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dynimage_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int STEP_DIV = 2;
  localparam int DEPTH    = 8;
  localparam int AW       = 3;
  localparam int ROUND    = 4 * SCAN_DIV;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSE  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_stop, i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [3:0]    i_wr_data;
  logic          o_wr_ack, o_running, o_step_pulse;
  logic [3:0]    o_an;
  logic [6:0]    o_seg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position within a 4-digit round, completed rounds, base
  int         m_state, m_p, m_rounds, m_base;
  logic [3:0] m_mem [DEPTH];
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_ack, m_step;

  dynimage_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .STEP_DIV (STEP_DIV),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .o_wr_ack     (o_wr_ack),
    .o_running    (o_running),
    .o_step_pulse (o_step_pulse),
    .o_an         (o_an),
    .o_seg        (o_seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic t,
                            input logic we, input logic [AW-1:0] a, input logic [3:0] d);
    logic [3:0] old_mem [DEPTH];
    logic [3:0] one;
    int dig;
    one = 4'b1000;
    old_mem = m_mem;
    if (r) begin
      m_state = M_IDLE; m_p = 0; m_rounds = 0; m_base = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 4'h0;
      m_an = 4'hF; m_seg = 7'h7F; m_ack = 1'b0; m_step = 1'b0;
      return;
    end
    m_ack  = we && (m_state != M_RUN);
    m_step = 1'b0;
    if (m_state == M_IDLE) begin
      if (s && !t) begin
        m_state = M_RUN; m_p = 0; m_rounds = 0; m_base = 0;
        m_an = 4'b0111; m_seg = dec(old_mem[0]);
      end
    end else begin
      if (m_state == M_RUN && m_p == ROUND - 1) begin
        m_rounds++;
        if (m_rounds == STEP_DIV) begin
          m_rounds = 0;
          m_base   = (m_base + 1) % DEPTH;
          m_step   = 1'b1;
        end
      end
      m_p = (m_p + 1) % ROUND;
      if (m_p % SCAN_DIV == 0) begin
        dig   = m_p / SCAN_DIV;
        m_an  = ~(one >> dig);
        m_seg = dec(old_mem[(m_base + dig) % DEPTH]);
      end
      if (t) begin
        if (m_state == M_RUN) begin
          m_state = M_PAUSE;
        end else begin
          m_state = M_IDLE; m_p = 0; m_rounds = 0; m_base = 0;
          m_an = 4'hF; m_seg = 7'h7F; m_step = 1'b0;
        end
      end else if (s) begin
        m_state = M_RUN;
      end
    end
    if (m_ack) m_mem[a] = d;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare on the falling edge
  task automatic tick(input logic r, input logic s, input logic t,
                      input logic we, input logic [AW-1:0] a, input logic [3:0] d);
    rst = r; i_start = s; i_stop = t; i_wr_en = we; i_wr_addr = a; i_wr_data = d;
    @(posedge clk);
    model_step(r, s, t, we, a, d);
    @(negedge clk);
    chk("an", o_an, m_an);
    chk("seg", o_seg, m_seg);
    chk("run_step_ack", {o_running, o_step_pulse, o_wr_ack},
        {(m_state == M_RUN), m_step, m_ack});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 4'h0);
  endtask

  initial begin
    int n;
    int steps;
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_wr_en = 1'b0;
    i_wr_addr = '0; i_wr_data = 4'h0;

    // Reset held three cycles, then idle
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 4'h0);
    idle(3);
    chk("reset_an", o_an, 4'b1111);
    chk("reset_seg", o_seg, 7'b1111111);

    // Load 1..8 in IDLE
    for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, AW'(i), 4'(i + 1));
    idle(1);

    // Start: first RUN cycle shows digit 0 = mem[0]
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 4'h0);
    chk("first_an", o_an, 4'b0111);
    chk("first_seg", o_seg, 7'b1111001);
    n = 0;
    do begin
      idle(1);
      n++;
    end while (!o_step_pulse && n < 200);
    chk("first_step_latency", n, 32);

    // Eight more scroll steps (wraps the base through 0)
    idle(8 * ROUND * STEP_DIV);

    // Pause: scanning continues, no scroll
    tick(1'b0, 1'b0, 1'b1, 1'b0, '0, 4'h0);
    steps = 0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (o_step_pulse) steps++;
    end
    chk("pause_steps", steps, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'hF);
    idle(2 * ROUND);
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 4'h0);
    idle(80);

    // Dropped write in RUN, simultaneous start/stop, then back to IDLE
    tick(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 4'hA);
    idle(ROUND);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0, 4'h0);
    idle(5);
    tick(1'b0, 1'b0, 1'b1, 1'b0, '0, 4'h0);
    chk("idle_an", o_an, 4'b1111);

    // Run to base 5, reset mid-RUN, restart on cleared memory
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 4'h0);
    idle(5 * ROUND * STEP_DIV + 3);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 4'h0);
    chk("midrun_rst_an", o_an, 4'b1111);
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 4'h0);
    chk("restart_seg", o_seg, 7'b1000000);
    idle(2 * ROUND);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 400) == 0, ($urandom % 20) == 0, ($urandom % 30) == 0,
           ($urandom % 4) == 0, AW'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dynimage_scan_ctrl
`default_nettype wire

// File: doc/dynimage_scan_ctrl.md
Name: dynimage_scan_ctrl

Overview:
- Controller that sequences the 4-digit 7-segment display datapath for the scrolling-image lab.
- Holds a small frame buffer of hex nibbles and time-multiplexes the digits (scan).
- Advances a scroll window through the buffer at a programmable rate.
- Offers run/pause/idle control and a write port so a host FSM or switches can load the message.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays lit; must be ≥2.
- STEP_DIV, 25: full 4-digit refresh rounds per scroll step; must be ≥1.
- DEPTH, 16: buffer length in nibbles; power of two, ≥4.
- AW, 4: address width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: IDLE→RUN (restart) or PAUSE→RUN (resume).
- stop  in  1  one-cycle pulse: RUN→PAUSE or PAUSE→IDLE.
- wr_en  in  1  buffer write request.
- wr_addr  in  AW  buffer write address.
- wr_data  in  4  hex nibble to store.
- wr_ack  out  1  high one cycle after an accepted write.
- running  out  1  high while in RUN.
- step_pulse  out  1  one-cycle pulse when the scroll base advances.
- an  out  4  digit enables, active-low; an[3] is the leftmost digit.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.

Behaviour:
- Reset (rst=1 at an edge):
  - State IDLE; base=0; scan_cnt=0; digit=0; round_cnt=0.
  - All buffer entries are set to 0.
  - Outputs: an=4'b1111, seg=7'b1111111, wr_ack=0, running=0, step_pulse=0.
  - Reset mid-RUN aborts immediately; the display goes blank on the next cycle.
- States:
  - IDLE: display blank, counters held at 0.
  - RUN: scanning and scrolling.
  - PAUSE: scanning continues, scroll frozen, round_cnt held.
- Transitions:
  - IDLE+start → RUN, clearing base, scan_cnt, digit and round_cnt.
  - PAUSE+start → RUN with no counters cleared.
  - RUN+stop → PAUSE.
  - PAUSE+stop → IDLE.
  - start and stop in the same cycle: stop wins.
  - start while in RUN and stop while in IDLE are ignored.
- Writes:
  - Accepted only in IDLE or PAUSE. mem[wr_addr] updates at the edge; wr_ack=1 on the next cycle.
  - A write in RUN is dropped and wr_ack stays 0.
  - A PAUSE write to a displayed address shows on that digit's next scan slot.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. At terminal it wraps and digit advances 0→1→2→3→0.
  - digit d drives an[3-d] low; all other an bits are high.
  - digit d shows mem[(base+d) mod DEPTH].
- Output timing:
  - an and seg are registered and change on the same edge (no ghosting).
  - The first RUN cycle after start already shows an=4'b0111 with seg=dec(mem[base]).
  - Each digit is held for exactly SCAN_DIV cycles.
- Scroll:
  - In RUN, when digit=3 and scan_cnt is at terminal, round_cnt increments.
  - At round_cnt terminal (STEP_DIV-1): round_cnt→0, base←(base+1) mod DEPTH, and step_pulse=1 for that one cycle.
  - The new base applies from digit 0 of the next round.
  - base wraps from DEPTH-1 to 0, so the window shows mem[DEPTH-1],mem[0],mem[1],mem[2].
- Decoder: hex→segments, active-low, gfedcba.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Arithmetic: all address sums are AW bits wide and wrap naturally. Counter widths are sized by $clog2 of SCAN_DIV and STEP_DIV.

Decomposition:
- Shared package dynimage_pkg holds:
  - The state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2).
  - The 16-entry segment code constant.
  - The blank constants AN_OFF=4'hF and SEG_OFF=7'h7F.
- One sub-module, hex7seg: combinational nibble→segment decoder, instantiated once ahead of the seg output register.

Test Plan (SCAN_DIV=4, STEP_DIV=2, DEPTH=8):
- rst held 3 cycles, then released → an=1111, seg=1111111, running=0, and mem reads 0 throughout.
- In IDLE write mem[0..7]=1,2,3,4,5,6,7,8 → wr_ack high the cycle after each write. Then start → next cycle an=0111, seg=1111001; after 4 cycles an=1011, seg=0100100; the an=1101 and an=1110 slots show 3 and 4.
- Continue in RUN → step_pulse exactly 32 cycles after RUN entry, with base=1; the next round shows 2,3,4,5. After 8 steps base wraps to 0; at base=6 the window shows 7,8,1,2.
- stop in RUN → PAUSE: scanning continues and no step_pulse occurs for 100 cycles. Write mem[1]=F in PAUSE → wr_ack=1 and the digit showing addr 1 changes to 0001110. start → resume with base unchanged; first step_pulse comes after the remaining round count.
- wr_en in RUN → wr_ack=0 and memory unchanged. start and stop in the same cycle in RUN → PAUSE. stop in PAUSE → IDLE, an=1111.
- rst asserted mid-RUN with base=5 → next cycle an=1111, base=0, memory all 0. A following start shows mem[0]=0 with seg=1000000.
